// File: rtl/mdu_iter.sv
// mdu_iter: iterative radix-2 multiply/divide unit owning the HI/LO registers.
//   clk, aclr (async active-high reset)
//   start/op/src_a/src_b: launch MULT(00) MULTU(01) DIV(10) DIVU(11) when idle
//   abort: cancel in-flight op; mthi/mtlo: write src_a to HI/LO when idle
//   busy: op in flight; done: one-cycle pulse after HI/LO update; hi/lo: registers
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             aclr,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             abort,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d;
    logic                 div_q, div_d, negq_q, negq_d, negr_q, negr_d, dz_q, dz_d, done_q, done_d;
    logic                 a_neg, b_neg, div_ge;
    logic [WIDTH-1:0]     a_mag, b_mag, div_rem;
    logic [WIDTH:0]       mul_sum, div_top;
    logic [2*WIDTH-1:0]   mul_next, div_next, prod_fix;
    assign a_neg    = ~op[0] & src_a[WIDTH-1];
    assign b_neg    = ~op[0] & src_b[WIDTH-1];
    assign a_mag    = a_neg ? -src_a : src_a;
    assign b_mag    = b_neg ? -src_b : src_b;
    // multiply: acc = {partial product, remaining multiplier bits}
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    // divide: acc = {partial remainder, dividend/quotient}; the shifted remainder needs one extra bit
    assign div_top  = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_ge   = div_top >= {1'b0, opnd_q};
    assign div_rem  = div_top[WIDTH-1:0] - opnd_q;
    assign div_next = div_ge ? {div_rem, acc_q[WIDTH-2:0], 1'b1} : {div_top[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    assign prod_fix = negq_q ? -acc_q : acc_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        div_d   = div_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = RUN;
                        cnt_d   = '0;
                        div_d   = op[1];
                        negq_d  = a_neg ^ b_neg;
                        negr_d  = a_neg;
                        dz_d    = op[1] & (src_b == '0);
                        opnd_d  = op[1] ? b_mag : a_mag;
                        acc_d   = {{WIDTH{1'b0}}, op[1] ? a_mag : b_mag};
                    end else begin
                        hi_d = mthi ? src_a : hi_q;
                        lo_d = mtlo ? src_a : lo_q;
                    end
                end
                RUN: begin
                    acc_d   = div_q ? div_next : mul_next;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = (&cnt_q) ? FIX : RUN;
                end
                FIX: begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    // restoring division by zero already leaves rem = |a|, so only lo needs forcing
                    hi_d = !div_q ? prod_fix[2*WIDTH-1:WIDTH] :
                           negr_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                    lo_d = !div_q ? prod_fix[WIDTH-1:0] :
                           dz_q   ? {WIDTH{1'b1}} : prod_fix[WIDTH-1:0];
                end
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            div_q   <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            div_q   <= div_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end
    assign busy = state_q != IDLE;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: table-driven check of mdu_iter results, latency and control corner cases.
module tb_mdu_iter;
    logic        clk = 1'b0, aclr = 1'b1, start = 1'b0, abort = 1'b0, mthi = 1'b0, mtlo = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] src_a = '0, src_b = '0;
    logic        busy, done;
    logic [31:0] hi, lo;
    int          checks = 0, errors = 0;
    mdu_iter #(.WIDTH(32)) dut (
        .clk(clk), .aclr(aclr), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .abort(abort), .mthi(mthi), .mtlo(mtlo), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, h, l;
    } vec_t;
    vec_t vecs[11];
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, output int n);
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1 n++;
        end while (!done && n < 40);
    endtask
    initial begin
        int n;
        logic seen;
        vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{2'b11, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
        vecs[4]  = '{2'b11, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
        vecs[5]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[6]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[7]  = '{2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003};
        vecs[8]  = '{2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
        vecs[9]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[10] = '{2'b10, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
        #2;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        @(negedge clk) aclr = 1'b0;
        // back-to-back ops also exercise start during the done cycle
        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, n);
            chk($sformatf("v%0d_lat", i), n, 33);
            chk($sformatf("v%0d_busy", i), {31'b0, busy}, 32'd0);
            chk($sformatf("v%0d_hi", i), hi, vecs[i].h);
            chk($sformatf("v%0d_lo", i), lo, vecs[i].l);
        end
        @(negedge clk);
        mthi = 1'b1; mtlo = 1'b1; src_a = 32'h55;
        @(negedge clk);
        chk("mthilo_hi", hi, 32'h55);
        chk("mthilo_lo", lo, 32'h55);
        mtlo = 1'b0; src_a = 32'h11;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b1; src_a = 32'h22;
        @(negedge clk);
        mtlo = 1'b0;
        chk("mthi_hi", hi, 32'h11);
        chk("mtlo_lo", lo, 32'h22);
        start = 1'b1; abort = 1'b1; op = 2'b01; src_a = 32'd4; src_b = 32'd4;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("idle_abort_blocks_start", {31'b0, busy}, 32'd0);
        start = 1'b1; op = 2'b11; src_a = 32'd9; src_b = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1 seen |= done;
        end
        chk("abort_no_done", {31'b0, seen}, 32'd0);
        chk("abort_hi", hi, 32'h11);
        chk("abort_lo", lo, 32'h22);
        @(negedge clk);
        start = 1'b1; op = 2'b01; src_a = 32'd3; src_b = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1 n++;
            start = (n == 5);
            mtlo  = (n == 7);
            src_a = 32'hDEAD;
            src_b = 32'd2;
        end while (!done && n < 40);
        start = 1'b0; mtlo = 1'b0;
        chk("ign_lat", n, 33);
        chk("ign_hi", hi, 32'd0);
        chk("ign_lo", lo, 32'd9);
        @(negedge clk);
        start = 1'b1; op = 2'b01; src_a = 32'd5; src_b = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #3 aclr = 1'b1;
        #1;
        chk("aclr_busy", {31'b0, busy}, 32'd0);
        chk("aclr_hi", hi, 32'd0);
        chk("aclr_lo", lo, 32'd0);
        @(negedge clk) aclr = 1'b0;
        run_op(2'b11, 32'd7, 32'd2, n);
        chk("post_rst_lat", n, 33);
        chk("post_rst_hi", hi, 32'd1);
        chk("post_rst_lo", lo, 32'd3);
        @(posedge clk);
        #1 chk("done_pulse_one_cycle", {31'b0, done}, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
